// File: rtl/usb_serial_pkg.sv
// usb_serial_pkg: shared constants for the USB serial bridge.
// Register map addresses, status/control bit positions and a count
// saturation helper used by the CPU read path.
package usb_serial_pkg;

  // Register addresses
  localparam logic [2:0] REG_DATA  = 3'd0;
  localparam logic [2:0] REG_STAT  = 3'd1;
  localparam logic [2:0] REG_CTRL  = 3'd2;
  localparam logic [2:0] REG_RXCNT = 3'd3;
  localparam logic [2:0] REG_TXCNT = 3'd4;

  // Status register bit positions
  localparam int ST_RXNE = 0;
  localparam int ST_TXNF = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_TXE  = 3;
  localparam int ST_IRQ  = 7;

  // Control register bit positions
  localparam int CT_RXIE = 0;
  localparam int CT_TXIE = 1;
  localparam int CT_LOOP = 2;

  // A 256-deep FIFO can hold 256 entries, which does not fit the 8-bit
  // count registers; clamp to 255.
  function automatic logic [7:0] sat_count(input logic [8:0] cnt);
    return cnt[8] ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/usb_serial_fifo.sv
// usb_serial_fifo: byte FIFO with occupancy count.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset (empties FIFO)
//   i_push, i_data   write request and byte (ignored when full)
//   i_pop            read request (ignored when empty)
//   o_data           head byte, combinational from storage
//   o_full, o_empty  derived from the count register
//   o_count          occupancy, 0..DEPTH
module usb_serial_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; clearing the pointers discards the contents.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/usb_serial_bridge.sv
// usb_serial_bridge: CPU register front end between the 6502 bus and the
// USB UART core byte pipes. CPU writes queue into a TX FIFO that drains to
// uart_in; uart_out bytes fill an RX FIFO popped by CPU reads.
// Optional loopback: define USB_SERIAL_BRIDGE_LOOP_EN to implement ctrl
// bit2, which routes uart_out straight to uart_in and freezes the pipe side
// of both FIFOs.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cs, we, addr, din, dout  bus access (one per cycle with cs=1), dout registered
//   IRQ                      registered level interrupt
//   uart_in_*                TX pipe toward the core
//   uart_out_*               RX pipe from the core
// Pipe handshake: a byte transfers on a clk edge where valid and ready are
// both high; valid never depends on ready, and ready never depends on valid
// (except the loopback path, which forwards ready from the other pipe).
module usb_serial_bridge
  import usb_serial_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       IRQ,
  output logic [7:0] uart_in_data,
  output logic       uart_in_valid,
  input  logic       uart_in_ready,
  input  logic [7:0] uart_out_data,
  input  logic       uart_out_valid,
  output logic       uart_out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  r_dout;
  logic        r_irq;
  logic [2:0]  r_ctrl;
  logic        r_ovf;
  logic        r_rdy;      // low in reset, high from the first edge after

  logic        w_rd_acc;
  logic        w_wr_acc;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_ovf_set;
  logic [7:0]  w_tx_head;
  logic [7:0]  w_rx_head;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [AW:0] w_tx_count;
  logic [AW:0] w_rx_count;
  logic [2:0]  w_ctrl_wr;
  logic [7:0]  w_stat;
  logic [7:0]  w_rd_data;

  assign w_rd_acc  = cs & ~we;
  assign w_wr_acc  = cs & we;
  // Full/empty are start-of-cycle flags: a same-cycle pipe transfer never
  // changes whether the CPU access succeeds.
  assign w_tx_push = w_wr_acc & (addr == REG_DATA) & ~w_tx_full;
  assign w_ovf_set = w_wr_acc & (addr == REG_DATA) & w_tx_full;
  assign w_rx_pop  = w_rd_acc & (addr == REG_DATA) & ~w_rx_empty;

`ifdef USB_SERIAL_BRIDGE_LOOP_EN
  logic w_loop;
  assign w_loop         = r_ctrl[CT_LOOP];
  assign uart_in_data   = w_loop ? uart_out_data  : w_tx_head;
  assign uart_in_valid  = w_loop ? uart_out_valid : ~w_tx_empty;
  assign uart_out_ready = w_loop ? uart_in_ready  : (r_rdy & ~w_rx_full);
  assign w_tx_pop       = ~w_loop & ~w_tx_empty & uart_in_ready;
  assign w_rx_push      = ~w_loop & uart_out_valid & r_rdy & ~w_rx_full;
  assign w_ctrl_wr      = din[2:0];
`else
  assign uart_in_data   = w_tx_head;
  assign uart_in_valid  = ~w_tx_empty;
  assign uart_out_ready = r_rdy & ~w_rx_full;
  assign w_tx_pop       = ~w_tx_empty & uart_in_ready;
  assign w_rx_push      = uart_out_valid & uart_out_ready;
  assign w_ctrl_wr      = {1'b0, din[1:0]};
`endif

  usb_serial_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_data  (din),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  usb_serial_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_data  (uart_out_data),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  always_comb begin
    w_stat          = 8'h00;
    w_stat[ST_RXNE] = ~w_rx_empty;
    w_stat[ST_TXNF] = ~w_tx_full;
    w_stat[ST_OVF]  = r_ovf;
    w_stat[ST_TXE]  = w_tx_empty;
    w_stat[ST_IRQ]  = r_irq;
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (addr)
      REG_DATA:  w_rd_data = w_rx_empty ? 8'h00 : w_rx_head;
      REG_STAT:  w_rd_data = w_stat;
      REG_CTRL:  w_rd_data = {5'b0, r_ctrl};
      REG_RXCNT: w_rd_data = sat_count(9'(w_rx_count));
      REG_TXCNT: w_rd_data = sat_count(9'(w_tx_count));
      default:   w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= 8'h00;
      r_irq  <= 1'b0;
      r_ctrl <= 3'b000;
      r_ovf  <= 1'b0;
      r_rdy  <= 1'b0;
    end else begin
      r_rdy <= 1'b1;
      // Built from start-of-cycle state, so IRQ trails FIFO changes by one cycle.
      r_irq <= (r_ctrl[CT_RXIE] & ~w_rx_empty) | (r_ctrl[CT_TXIE] & w_tx_empty);
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (w_wr_acc && addr == REG_STAT && din[ST_OVF])
        r_ovf <= 1'b0;
      if (w_wr_acc && addr == REG_CTRL)
        r_ctrl <= w_ctrl_wr;
      if (w_rd_acc)
        r_dout <= w_rd_data;
    end
  end

  assign dout = r_dout;
  assign IRQ  = r_irq;

endmodule

// File: tb/tb_usb_serial_bridge.sv
module tb_usb_serial_bridge;

  logic       clk = 1'b0;
  logic       rst;
  logic       cs;
  logic       we;
  logic [2:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;
  logic [7:0] uart_out_data;
  logic       uart_out_valid;
  logic       uart_out_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_q[$];

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[16];

  usb_serial_bridge #(.DEPTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .cs             (cs),
    .we             (we),
    .addr           (addr),
    .din            (din),
    .dout           (dout),
    .IRQ            (irq),
    .uart_in_data   (uart_in_data),
    .uart_in_valid  (uart_in_valid),
    .uart_in_ready  (uart_in_ready),
    .uart_out_data  (uart_out_data),
    .uart_out_valid (uart_out_valid),
    .uart_out_ready (uart_out_ready)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Driver and check tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    cs = 1'b0;
    d = dout;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] got;
    bus_rd(a, got);
    check8(name, got, exp);
  endtask

  // Offers n consecutive bytes on uart_out, advancing only on accepted edges.
  task automatic push_rx(input logic [7:0] first, input int n);
    int k;
    int budget;
    k = 0;
    budget = 0;
    uart_out_valid = 1'b1;
    uart_out_data  = first;
    while (k < n && budget < 100) begin
      logic acc;
      acc = uart_out_ready;
      tick();
      budget++;
      if (acc) begin
        k++;
        uart_out_data = first + 8'(k);
      end
    end
    uart_out_valid = 1'b0;
    if (k < n) begin
      n_checks++;
      n_errors++;
      $display("FAIL rx_push_timeout: got %0d accepted expected %0d", k, n);
    end
  endtask

  // Lets n bytes leave uart_in and compares each against the expected queue.
  task automatic drain_tx(input string name, input int n);
    uart_in_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      logic [7:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      check8({name, "_valid"}, {7'b0, uart_in_valid}, 8'h01);
      check8($sformatf("%s_byte%0d", name, i), uart_in_data, e);
      tick();
    end
    uart_in_ready = 1'b0;
  endtask

  function automatic vec_t mk(input logic w, input logic [2:0] a,
                              input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.we = w; v.addr = a; v.din = d; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [7:0] got;

    // Register map vectors from the idle, just-reset state
    vecs[0]  = mk(1'b0, 3'd1, 8'h00, 8'h0A);  // status: txnf, txe
    vecs[1]  = mk(1'b0, 3'd2, 8'h00, 8'h00);
    vecs[2]  = mk(1'b1, 3'd2, 8'h03, 8'h00);
    vecs[3]  = mk(1'b0, 3'd2, 8'h00, 8'h03);
    vecs[4]  = mk(1'b1, 3'd2, 8'hF8, 8'h00);  // unimplemented bits only
    vecs[5]  = mk(1'b0, 3'd2, 8'h00, 8'h00);
    vecs[6]  = mk(1'b0, 3'd0, 8'h00, 8'h00);  // RX empty read
    vecs[7]  = mk(1'b1, 3'd3, 8'h55, 8'h00);  // write to read-only count
    vecs[8]  = mk(1'b0, 3'd3, 8'h00, 8'h00);
    vecs[9]  = mk(1'b0, 3'd4, 8'h00, 8'h00);
    vecs[10] = mk(1'b1, 3'd5, 8'hAA, 8'h00);
    vecs[11] = mk(1'b0, 3'd5, 8'h00, 8'h00);
    vecs[12] = mk(1'b0, 3'd6, 8'h00, 8'h00);
    vecs[13] = mk(1'b0, 3'd7, 8'h00, 8'h00);
    vecs[14] = mk(1'b1, 3'd1, 8'hFF, 8'h00);
    vecs[15] = mk(1'b0, 3'd1, 8'h00, 8'h0A);

    // Reset
    rst = 1'b0; cs = 1'b0; we = 1'b0; addr = 3'd0; din = 8'h00;
    uart_in_ready = 1'b0; uart_out_data = 8'h00; uart_out_valid = 1'b0;
    repeat (3) tick();
    check8("rst_dout", dout, 8'h00);
    check8("rst_irq", {7'b0, irq}, 8'h00);
    check8("rst_in_valid", {7'b0, uart_in_valid}, 8'h00);
    check8("rst_out_ready", {7'b0, uart_out_ready}, 8'h00);
    rst = 1'b1;
    check8("rel_out_ready_pre", {7'b0, uart_out_ready}, 8'h00);
    tick();
    check8("rel_out_ready", {7'b0, uart_out_ready}, 8'h01);

    // Table-driven register vectors
    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) begin
        bus_wr(vecs[i].addr, vecs[i].din);
      end else begin
        bus_rd(vecs[i].addr, got);
        check8($sformatf("vec%0d", i), got, vecs[i].exp);
      end
    end
    tick();
    check8("dout_hold_idle", dout, 8'h0A);
    bus_wr(3'd2, 8'h00);
    check8("dout_hold_write", dout, 8'h0A);

    // TX path
    for (int i = 0; i < 3; i++) begin
      bus_wr(3'd0, 8'h41 + 8'(i));
      exp_q.push_back(8'h41 + 8'(i));
    end
    rd_check("tx_cnt3", 3'd4, 8'h03);
    check8("tx_head", uart_in_data, 8'h41);
    drain_tx("tx_path", 3);
    check8("tx_path_empty", {7'b0, uart_in_valid}, 8'h00);

    // TX overflow and simultaneous pop against a full FIFO
    for (int i = 0; i < 17; i++) begin
      bus_wr(3'd0, 8'h50 + 8'(i));
      if (i < 16) exp_q.push_back(8'h50 + 8'(i));
    end
    rd_check("tx_cnt_full", 3'd4, 8'h10);
    rd_check("tx_ovf_stat", 3'd1, 8'h04);
    uart_in_ready = 1'b1;
    cs = 1'b1; we = 1'b1; addr = 3'd0; din = 8'hEE;
    check8("tx_simul_head", uart_in_data, exp_q.pop_front());
    tick();
    cs = 1'b0; we = 1'b0; uart_in_ready = 1'b0;
    rd_check("tx_simul_cnt", 3'd4, 8'h0F);
    rd_check("tx_simul_stat", 3'd1, 8'h06);
    bus_wr(3'd1, 8'h04);
    rd_check("tx_ovf_clr", 3'd1, 8'h02);
    drain_tx("tx_ovf", 15);
    check8("tx_ovf_empty", {7'b0, uart_in_valid}, 8'h00);

    // RX fill and backpressure
    push_rx(8'h00, 16);
    uart_out_valid = 1'b1; uart_out_data = 8'h10;
    check8("rx_full_ready", {7'b0, uart_out_ready}, 8'h00);
    tick(); tick();
    check8("rx_full_ready_hold", {7'b0, uart_out_ready}, 8'h00);
    rd_check("rx_cnt_full", 3'd3, 8'h10);
    uart_out_valid = 1'b0;
    for (int i = 0; i < 16; i++)
      rd_check($sformatf("rx_rd%0d", i), 3'd0, 8'(i));
    rd_check("rx_rd_empty", 3'd0, 8'h00);
    rd_check("rx_empty_stat", 3'd1, 8'h0A);
    push_rx(8'h10, 4);
    rd_check("rx_cnt4", 3'd3, 8'h04);
    for (int i = 0; i < 4; i++)
      rd_check($sformatf("rx_late%0d", i), 3'd0, 8'h10 + 8'(i));

    // IRQ
    bus_wr(3'd2, 8'h01);
    tick();
    check8("irq_rx_idle", {7'b0, irq}, 8'h00);
    push_rx(8'hA5, 1);
    tick();
    check8("irq_rx_set", {7'b0, irq}, 8'h01);
    rd_check("irq_rx_data", 3'd0, 8'hA5);
    tick();
    check8("irq_rx_clr", {7'b0, irq}, 8'h00);
    bus_wr(3'd2, 8'h02);
    tick();
    check8("irq_tx_set", {7'b0, irq}, 8'h01);
    rd_check("irq_stat", 3'd1, 8'h8A);
    bus_wr(3'd2, 8'h00);
    tick();
    check8("irq_off", {7'b0, irq}, 8'h00);

    // Simultaneous RX push and CPU pop
    push_rx(8'h11, 1);
    cs = 1'b1; we = 1'b0; addr = 3'd0;
    uart_out_valid = 1'b1; uart_out_data = 8'h22;
    tick();
    cs = 1'b0; uart_out_valid = 1'b0;
    check8("rx_simul_data", dout, 8'h11);
    rd_check("rx_simul_cnt", 3'd3, 8'h01);
    rd_check("rx_simul_next", 3'd0, 8'h22);

    // Read of an empty RX while a byte lands the same cycle
    cs = 1'b1; we = 1'b0; addr = 3'd0;
    uart_out_valid = 1'b1; uart_out_data = 8'h33;
    tick();
    cs = 1'b0; uart_out_valid = 1'b0;
    check8("rx_empty_simul", dout, 8'h00);
    rd_check("rx_empty_simul_cnt", 3'd3, 8'h01);
    rd_check("rx_empty_simul_next", 3'd0, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/usb_serial_bridge.md
Name: usb_serial_bridge

Overview:
CPU-side register and buffering stage between the 6502 bus and the USB UART core's byte pipes.
- TX FIFO: CPU writes queue here, then drain into the core's uart_in pipe (device to host).
- RX FIFO: fills from the core's uart_out pipe (host to device) and is popped by CPU reads.
- Also provides status, control, counts and a level IRQ.
- Instantiated inside the USB serial wrapper in place of the pipe loopback.

Parameters:
- DEPTH, 16, entries per FIFO; power of 2, range 4..256.
- AW, $clog2(DEPTH), FIFO pointer width; derived, do not override.

Ports:
- clk  input  1  system clock (48 MHz).
- rst  input  1  reset; asynchronous, active-low.
- cs  input  1  chip select; each clk cycle with cs=1 is one bus access.
- we  input  1  write enable.
- addr  input  3  register select.
- din  input  8  write data.
- dout  output  8  registered read data.
- IRQ  output  1  registered level interrupt, active-high.
- uart_in_data  output  8  byte to core (TX FIFO head).
- uart_in_valid  output  1  TX FIFO non-empty.
- uart_in_ready  input  1  core accepts byte.
- uart_out_data  input  8  byte from core.
- uart_out_valid  input  1  core byte valid.
- uart_out_ready  output  1  RX FIFO not full.

Behaviour:
- Reset (rst=0, async), all outputs and state cleared:
  - FIFOs empty, pointers and counts 0.
  - dout=0, IRQ=0, uart_in_valid=0, uart_out_ready=0, ctrl=0, ovf=0.
  - After release: uart_out_ready=1 on the first clk edge.
  - Reset mid-transfer discards all FIFO contents.
- Registers:
  - addr 0 write: push din to TX FIFO. If TX is full (flag as of start of cycle), the byte is dropped and sticky ovf is set. A same-cycle pipe pop does not rescue the write.
  - addr 0 read: dout <= RX head and pop. If RX is empty (start of cycle), dout <= 0x00, no pop, even if a push lands the same cycle.
  - addr 1 read (status): bit0 rx_nonempty, bit1 tx_notfull, bit2 ovf, bit3 tx_empty, bit7 IRQ, others 0.
  - addr 1 write: din[2]=1 clears ovf; other bits ignored.
  - addr 2 R/W (ctrl): bit0 rx_ie, bit1 tx_ie, bit2 loop (see Optional Feature); unimplemented bits read 0.
  - addr 3 read: RX count, saturated at 255. addr 4 read: TX count, saturated at 255.
  - addr 5–7: reads 0x00, writes ignored.
  - Writes to read-only registers have no effect.
- Read latency: dout is updated on the clk edge ending the access cycle; it holds when cs=0 or we=1.
- TX pipe:
  - uart_in_valid = !tx_empty; uart_in_data = TX head (combinational from FIFO RAM/regs).
  - Pop when uart_in_valid & uart_in_ready.
  - Simultaneous CPU push and pipe pop on a non-full FIFO: both occur, count unchanged.
- RX pipe:
  - uart_out_ready = !rx_full (registered flag).
  - Push when uart_out_valid & uart_out_ready. Pipe data is never lost.
  - Simultaneous push and CPU pop: both occur.
- FIFO arithmetic:
  - Pointers AW bits, wrap modulo DEPTH.
  - Count AW+1 bits, range 0..DEPTH.
  - full = (count==DEPTH), empty = (count==0).
- IRQ: registered each cycle as (rx_ie & rx_nonempty) | (tx_ie & tx_empty). It lags the FIFO state change by one cycle and is level-sensitive, not latched.

Optional Feature:
- Macro: USB_SERIAL_BRIDGE_LOOP_EN.
- Defined: ctrl bit2 (loop) is implemented.
  - loop=1: uart_out_data/valid route directly to uart_in_data/valid, and uart_out_ready = uart_in_ready.
  - Both FIFOs are frozen: no push or pop from either pipe. CPU data writes still push TX; CPU reads still pop RX.
  - Switching loop takes effect on the next cycle.
- Undefined: ctrl bit2 reads 0, writes ignored, no loop path synthesized.

Decomposition:
- Package usb_serial_pkg:
  - register address constants: REG_DATA=0, REG_STAT=1, REG_CTRL=2, REG_RXCNT=3, REG_TXCNT=4.
  - status bit indices: ST_RXNE=0, ST_TXNF=1, ST_OVF=2, ST_TXE=3, ST_IRQ=7.
  - ctrl bit indices: CT_RXIE=0, CT_TXIE=1, CT_LOOP=2.
- Sub-module usb_serial_fifo:
  - parameterized by DEPTH; push/pop, data in/out, full, empty, count.
  - instantiated twice (TX and RX).

Test Plan:
- Reset: hold rst=0, then release → dout=0x00, IRQ=0, status read=0x0A (txnf, txe), uart_in_valid=0, uart_out_ready=1 one cycle after release.
- TX path: uart_in_ready=0; write 0x41,0x42,0x43 to addr0 → TX count=3, uart_in_data=0x41. Then uart_in_ready=1 → 0x41,0x42,0x43 emitted in order on 3 consecutive cycles, uart_in_valid=0 afterwards.
- TX overflow: DEPTH=16, uart_in_ready=0; write 17 bytes → TX count=16, status bit2=1, 17th byte never emitted. Write 0x04 to addr1 → bit2=0.
- RX full/backpressure: present 20 bytes 0x00..0x13 with uart_out_valid=1 → uart_out_ready=0 after 16 accepted, RX count=16. Read addr0 sixteen times → 0x00..0x0F. One more read → 0x00 with rxne=0. Bytes 0x10..0x13 are then accepted.
- IRQ: ctrl=0x01, push one RX byte → IRQ=1 within 2 cycles of the push. Read it → IRQ=0 one cycle later. ctrl=0x02 with TX empty → IRQ=1.
- Simultaneous events (RX): RX holding 1 byte; read addr0 in the same cycle a new byte is pushed → old byte returned, RX count stays 1.
- Simultaneous events (TX): TX full; write while the pipe pops → write dropped, ovf=1, count=15.
